regfile_cmd_ctrl: RTL and testbench
===================================

# regfile_cmd_ctrl

Command sequencer that turns a byte stream from the serial receiver into register-file write and read transactions and returns read data to the serial transmitter. It sits between the UART RX/TX parallel interfaces and the register file, and is the only master driving the register file's WrEn/RdEn/Address/WrData. One frame is processed at a time. Malformed or overlapping input is rejected with an error pulse and never reaches the register file.

## Interface
- data_width, 8, width of the data bytes, the register-file word, and the TX/RX parallel data
- address_width, 4, register-file address width; the address byte must have bits [data_width-1:address_width] equal to zero

- clk  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  data_width  received byte
- RX_D_VLD  in  1  RX_P_DATA valid for this cycle (one-cycle strobe per byte)
- RdData  in  data_width  register-file read data
- RdData_Valid  in  1  register-file read data valid strobe
- TX_Busy  in  1  transmitter busy; a new byte may be offered only while low
- WrEn  out  1  register-file write enable, one-cycle pulse
- RdEn  out  1  register-file read enable, one-cycle pulse
- Address  out  address_width  register-file address
- WrData  out  data_width  register-file write data
- TX_P_DATA  out  data_width  byte to transmit
- TX_D_VLD  out  1  TX_P_DATA valid, one-cycle pulse
- Ctrl_Busy  out  1  high whenever the FSM is not in IDLE
- Cmd_Err  out  1  one-cycle error pulse

## Operation
- Opcodes:
  - WR_CMD = 0xAA; frame is opcode, address, data.
  - RD_CMD = 0xBB; frame is opcode, address.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_SEND.
- IDLE:
  - RX_D_VLD with 0xAA goes to WR_ADDR.
  - RX_D_VLD with 0xBB goes to RD_ADDR.
  - Any other byte pulses Cmd_Err and stays in IDLE.
- WR_ADDR / RD_ADDR, on RX_D_VLD:
  - If the upper address bits are nonzero, pulse Cmd_Err and go to IDLE.
  - Otherwise latch Address and go to WR_DATA / RD_EXEC.
- WR_DATA, on RX_D_VLD: latch WrData and go to WR_EXEC.
- WR_EXEC: WrEn = 1 for exactly one cycle, then IDLE.
- RD_EXEC: RdEn = 1 for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - On RdData_Valid, latch RdData into TX_P_DATA and go to TX_SEND.
  - If no RdData_Valid within 4 cycles (2-bit watchdog), pulse Cmd_Err and go to IDLE.
- TX_SEND: when TX_Busy = 0, pulse TX_D_VLD for one cycle and go to IDLE. Otherwise wait indefinitely.
- RX_D_VLD in WR_EXEC, RD_EXEC, RD_WAIT or TX_SEND: the byte is dropped and Cmd_Err is pulsed; the current frame continues.
- WrEn and RdEn are never high together.
- Address and WrData hold their last latched values outside the pulses.

## Timing
- All outputs are registered.
- Reset values: WrEn = 0, RdEn = 0, Address = 0, WrData = 0, TX_P_DATA = 0, TX_D_VLD = 0, Ctrl_Busy = 0, Cmd_Err = 0; state IDLE; watchdog = 0.
- Write latency: WrEn is high in the cycle after the cycle in which the data byte is sampled.
- Read latency: RdEn is high in the cycle after the address byte is sampled.
- With a one-cycle register file, TX_D_VLD rises 3 cycles after RdEn when TX_Busy = 0.
- Bytes may arrive back-to-back (RX_D_VLD high on consecutive cycles) during the opcode, address and data phases.
- Ctrl_Busy is high from the cycle after the opcode is accepted until the FSM re-enters IDLE.
- Reset asserted mid-frame aborts the frame immediately. No WrEn, RdEn or TX_D_VLD is issued after reset releases.

## Structure
- Shared package regfile_cmd_pkg holds:
  - opcode constants WR_CMD and RD_CMD;
  - the state enum;
  - the watchdog limit RD_TIMEOUT = 4.
- Single module; no sub-module. The watchdog is an inline 2-bit counter, cleared on entry to RD_WAIT.

## Test plan
- Write frame 0xAA, 0x05, 0x3C -> one WrEn pulse with Address = 5 and WrData = 0x3C; Ctrl_Busy high for 3 cycles.
- Read frame 0xBB, 0x02 with RdData = 0x81, TX_Busy = 0 -> RdEn pulse with Address = 2, then a TX_D_VLD pulse with TX_P_DATA = 0x81.
- Read with TX_Busy held high for 10 cycles -> TX_D_VLD is deferred until the first cycle TX_Busy = 0; TX_P_DATA stays 0x81.
- Error cases -> Cmd_Err pulse each time; no WrEn or RdEn:
  - opcode 0x11;
  - address byte 0x15 after 0xAA;
  - RdData_Valid never returned after RdEn (pulse 4 cycles into RD_WAIT).
- RST low during WR_DATA, then frame 0xBB, 0x03 -> all outputs are 0 during reset; no stale WrEn; the read of address 3 completes normally.

Source files
------------

// File: rtl/regfile_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_cmd_pkg
//  Description : Shared definitions for the register-file command sequencer:
//                command opcodes, read-data watchdog limit and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_cmd_pkg;

    // Frame opcodes (first byte of every frame)
    localparam logic [7:0] WR_CMD = 8'hAA;  // opcode, address, data
    localparam logic [7:0] RD_CMD = 8'hBB;  // opcode, address

    // Number of RD_WAIT cycles allowed before a read is abandoned
    localparam int RD_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        WR_EXEC = 3'd3,
        RD_ADDR = 3'd4,
        RD_EXEC = 3'd5,
        RD_WAIT = 3'd6,
        TX_SEND = 3'd7
    } state_t;

endpackage : regfile_cmd_pkg
`default_nettype wire

// File: rtl/regfile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_cmd_ctrl
//  Description : Turns the UART RX byte stream into register-file write/read
//                transactions and hands read data back to the UART TX.
//                One frame at a time; malformed or overlapping bytes raise a
//                one-cycle Cmd_Err and never reach the register file.
//  Ports       : clk, RST (async, active low)
//                RX_P_DATA/RX_D_VLD      - received byte + strobe
//                RdData/RdData_Valid     - register-file read return
//                TX_Busy                 - transmitter busy
//                WrEn/RdEn/Address/WrData- register-file master interface
//                TX_P_DATA/TX_D_VLD      - byte to transmit + strobe
//                Ctrl_Busy               - sequencer not idle
//                Cmd_Err                 - one-cycle error pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_cmd_ctrl
    import regfile_cmd_pkg::*;
#(
    parameter int data_width    = 8,
    parameter int address_width = 4
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic [data_width-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [data_width-1:0]    RdData,
    input  logic                     RdData_Valid,
    input  logic                     TX_Busy,
    output logic                     WrEn,
    output logic                     RdEn,
    output logic [address_width-1:0] Address,
    output logic [data_width-1:0]    WrData,
    output logic [data_width-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     Ctrl_Busy,
    output logic                     Cmd_Err
);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_wd;          // read-data watchdog

    logic        w_wr_en;
    logic        w_rd_en;
    logic        w_tx_vld;
    logic        w_cmd_err;
    logic        w_addr_ld;
    logic        w_data_ld;
    logic        w_tx_ld;
    logic        w_wd_clr;
    logic        w_wd_inc;
    logic        w_addr_ok;

    // An address byte is legal only if every bit above the address field is 0
    assign w_addr_ok = (RX_P_DATA[data_width-1:address_width] == '0);

    // ------------------------------------------------------------------------
    // Next-state and next-output decode. Every output is registered, so the
    // pulse decisions are made here one cycle ahead of when they appear.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_rd_en      = 1'b0;
        w_tx_vld     = 1'b0;
        w_cmd_err    = 1'b0;
        w_addr_ld    = 1'b0;
        w_data_ld    = 1'b0;
        w_tx_ld      = 1'b0;
        w_wd_clr     = 1'b0;
        w_wd_inc     = 1'b0;

        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == data_width'(WR_CMD)) begin
                        w_next_state = WR_ADDR;
                    end else if (RX_P_DATA == data_width'(RD_CMD)) begin
                        w_next_state = RD_ADDR;
                    end else begin
                        w_cmd_err = 1'b1;
                    end
                end
            end

            WR_ADDR: begin
                if (RX_D_VLD) begin
                    if (w_addr_ok) begin
                        w_addr_ld    = 1'b1;
                        w_next_state = WR_DATA;
                    end else begin
                        w_cmd_err    = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end

            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_data_ld    = 1'b1;
                    w_wr_en      = 1'b1;   // registered: high during WR_EXEC
                    w_next_state = WR_EXEC;
                end
            end

            WR_EXEC: begin
                w_cmd_err    = RX_D_VLD;
                w_next_state = IDLE;
            end

            RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (w_addr_ok) begin
                        w_addr_ld    = 1'b1;
                        w_rd_en      = 1'b1;   // registered: high during RD_EXEC
                        w_next_state = RD_EXEC;
                    end else begin
                        w_cmd_err    = 1'b1;
                        w_next_state = IDLE;
                    end
                end
            end

            RD_EXEC: begin
                w_cmd_err    = RX_D_VLD;
                w_wd_clr     = 1'b1;           // watchdog starts fresh in RD_WAIT
                w_next_state = RD_WAIT;
            end

            RD_WAIT: begin
                w_cmd_err = RX_D_VLD;
                if (RdData_Valid) begin
                    w_tx_ld      = 1'b1;
                    w_next_state = TX_SEND;
                end else if (r_wd == 2'(RD_TIMEOUT - 1)) begin
                    w_cmd_err    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_wd_inc     = 1'b1;
                end
            end

            TX_SEND: begin
                w_cmd_err = RX_D_VLD;
                if (!TX_Busy) begin
                    w_tx_vld     = 1'b1;
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, watchdog and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_wd      <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            Ctrl_Busy <= 1'b0;
            Cmd_Err   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            WrEn      <= w_wr_en;
            RdEn      <= w_rd_en;
            TX_D_VLD  <= w_tx_vld;
            Cmd_Err   <= w_cmd_err;
            Ctrl_Busy <= (w_next_state != IDLE);

            if (w_addr_ld) begin
                Address <= RX_P_DATA[address_width-1:0];
            end
            if (w_data_ld) begin
                WrData <= RX_P_DATA;
            end
            if (w_tx_ld) begin
                TX_P_DATA <= RdData;
            end

            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + 2'd1;
            end
        end
    end

endmodule : regfile_cmd_ctrl
`default_nettype wire

// File: tb/tb_regfile_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_cmd_ctrl
//  Description : Self-checking bench for regfile_cmd_ctrl. A simple one-cycle
//                register file sits on the DUT master port; a monitor logs
//                every WrEn/RdEn/TX_D_VLD/Cmd_Err event with its cycle number
//                and the expected transactions come from a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_cmd_ctrl;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] RX_P_DATA = '0;
    logic       RX_D_VLD = 1'b0;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic       TX_Busy = 1'b0;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic [7:0] TX_P_DATA;
    logic       TX_D_VLD;
    logic       Ctrl_Busy;
    logic       Cmd_Err;

    regfile_cmd_ctrl dut (
        .clk          (clk),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .TX_Busy      (TX_Busy),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .TX_P_DATA    (TX_P_DATA),
        .TX_D_VLD     (TX_D_VLD),
        .Ctrl_Busy    (Ctrl_Busy),
        .Cmd_Err      (Cmd_Err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle register file; rf_mute suppresses the read return
    logic [7:0] rf_mem [16];
    logic       rf_mute = 1'b0;
    always @(posedge clk) begin
        if (WrEn) rf_mem[Address] <= WrData;
        RdData_Valid <= RdEn && !rf_mute;
        RdData       <= rf_mem[Address];
    end

    // Event log
    int         wr_cyc[$];
    logic [3:0] wr_addr[$];
    logic [7:0] wr_data[$];
    int         rd_cyc[$];
    logic [3:0] rd_addr[$];
    int         tx_cyc[$];
    logic [7:0] tx_data[$];
    int         err_cyc[$];
    int         busy_cnt = 0;
    int         both_cnt = 0;

    always @(negedge clk) begin
        if (WrEn)     begin wr_cyc.push_back(cyc); wr_addr.push_back(Address); wr_data.push_back(WrData); end
        if (RdEn)     begin rd_cyc.push_back(cyc); rd_addr.push_back(Address); end
        if (TX_D_VLD) begin tx_cyc.push_back(cyc); tx_data.push_back(TX_P_DATA); end
        if (Cmd_Err)  err_cyc.push_back(cyc);
        if (Ctrl_Busy) busy_cnt++;
        if (WrEn && RdEn) both_cnt++;
    end

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_mem [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        rd_cyc.delete(); rd_addr.delete();
        tx_cyc.delete(); tx_data.delete();
        err_cyc.delete();
        busy_cnt = 0;
    endtask

    task automatic idle_cycle();
        RX_D_VLD = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge clk); #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) idle_cycle();
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check({tag, "_WrEn"},      32'(WrEn),      0);
        check({tag, "_RdEn"},      32'(RdEn),      0);
        check({tag, "_Address"},   32'(Address),   0);
        check({tag, "_WrData"},    32'(WrData),    0);
        check({tag, "_TX_P_DATA"}, 32'(TX_P_DATA), 0);
        check({tag, "_TX_D_VLD"},  32'(TX_D_VLD),  0);
        check({tag, "_Ctrl_Busy"}, 32'(Ctrl_Busy), 0);
        check({tag, "_Cmd_Err"},   32'(Cmd_Err),   0);
    endtask

    // Write frame whose data byte was sampled at edge t: WrEn in cycle t
    task automatic expect_write(input int t, input logic [3:0] a, input logic [7:0] d);
        check("wr_count", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1) begin
            check("wr_cycle", wr_cyc[0], t);
            check("wr_addr",  32'(wr_addr[0]), 32'(a));
            check("wr_data",  32'(wr_data[0]), 32'(d));
        end
        check("wr_no_rd",  rd_cyc.size(), 0);
        check("wr_no_err", err_cyc.size(), 0);
    endtask

    // Read frame whose address byte was sampled at edge t: RdEn in cycle t
    task automatic expect_read(input int t, input logic [3:0] a, input logic [7:0] d, input int txc);
        check("rd_count", rd_cyc.size(), 1);
        if (rd_cyc.size() == 1) begin
            check("rd_cycle", rd_cyc[0], t);
            check("rd_addr",  32'(rd_addr[0]), 32'(a));
        end
        check("tx_count", tx_cyc.size(), 1);
        if (tx_cyc.size() == 1) begin
            check("tx_cycle", tx_cyc[0], txc);
            check("tx_data",  32'(tx_data[0]), 32'(d));
        end
        check("rd_no_wr", wr_cyc.size(), 0);
    endtask

    task automatic expect_err(input int t);
        check("err_count", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("err_cycle", err_cyc[0], t);
        check("err_no_wr", wr_cyc.size(), 0);
        check("err_no_rd", rd_cyc.size(), 0);
        check("err_no_tx", tx_cyc.size(), 0);
    endtask

    initial begin
        int         t;
        int         t_err;
        int         m;
        int         kind;
        logic [7:0] a8;
        logic [7:0] d;
        logic [7:0] op;
        logic [3:0] a;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        RST = 1'b1;
        repeat (2) idle_cycle();
        clear_logs();

        // ---- preload every address through the DUT ----
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            send_byte(8'hAA); send_byte(8'(i)); send_byte(d);
            t = cyc;
            repeat (3) idle_cycle();
            expect_write(t, 4'(i), d);
            exp_mem[i] = d;
            clear_logs();
        end

        // ---- write 0xAA 0x05 0x3C, back-to-back ----
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        t = cyc;
        repeat (4) idle_cycle();
        expect_write(t, 4'h5, 8'h3C);
        check("wr_busy_cycles", busy_cnt, 3);
        exp_mem[5] = 8'h3C;
        clear_logs();

        // ---- put 0x81 at address 2, then read it back ----
        send_byte(8'hAA); send_byte(8'h02); send_byte(8'h81);
        repeat (3) idle_cycle();
        exp_mem[2] = 8'h81;
        clear_logs();
        send_byte(8'hBB); send_byte(8'h02);
        t = cyc;
        repeat (6) idle_cycle();
        expect_read(t, 4'h2, 8'h81, t + 3);
        check("rd_no_err", err_cyc.size(), 0);
        clear_logs();

        // ---- read with TX_Busy held for 10 cycles, stray byte in TX_SEND ----
        TX_Busy = 1'b1;
        send_byte(8'hBB); send_byte(8'h02);
        t = cyc;
        t_err = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                send_byte(8'hAA);
                t_err = cyc;
            end else begin
                idle_cycle();
            end
        end
        @(negedge clk);
        check("busy_tx_held",   tx_cyc.size(), 0);
        check("busy_tx_data",   32'(TX_P_DATA), 32'h81);
        check("busy_ctrl_busy", 32'(Ctrl_Busy), 1);
        @(posedge clk); #1;
        TX_Busy = 1'b0;
        m = cyc;
        repeat (4) idle_cycle();
        check("busy_rd_count", rd_cyc.size(), 1);
        check("busy_tx_count", tx_cyc.size(), 1);
        if (tx_cyc.size() == 1) begin
            check("busy_tx_cycle", tx_cyc[0], m + 1);
            check("busy_tx_val",   32'(tx_data[0]), 32'h81);
        end
        check("stray_err_count", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("stray_err_cycle", err_cyc[0], t_err);
        check("stray_no_wr", wr_cyc.size(), 0);
        clear_logs();

        // ---- bad opcode ----
        send_byte(8'h11);
        t = cyc;
        repeat (4) idle_cycle();
        expect_err(t);
        check("badop_busy", busy_cnt, 0);
        clear_logs();

        // ---- bad address after write opcode ----
        send_byte(8'hAA); send_byte(8'h15);
        t = cyc;
        repeat (4) idle_cycle();
        expect_err(t);
        clear_logs();

        // ---- read data never returned: watchdog ----
        rf_mute = 1'b1;
        send_byte(8'hBB); send_byte(8'h07);
        t = cyc;
        repeat (10) idle_cycle();
        check("wd_rd_count", rd_cyc.size(), 1);
        if (rd_cyc.size() == 1) check("wd_rd_cycle", rd_cyc[0], t);
        check("wd_err_count", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("wd_err_cycle", err_cyc[0], t + 5);
        check("wd_no_tx", tx_cyc.size(), 0);
        check("wd_no_wr", wr_cyc.size(), 0);
        rf_mute = 1'b0;
        clear_logs();

        // ---- reset during WR_DATA, then read address 3 ----
        send_byte(8'hAA); send_byte(8'h09);
        RST = 1'b0;
        check_outputs_zero("midrst");
        repeat (2) idle_cycle();
        RST = 1'b1;
        repeat (5) idle_cycle();
        check("midrst_no_wr",  wr_cyc.size(), 0);
        check("midrst_no_err", err_cyc.size(), 0);
        clear_logs();
        send_byte(8'hBB); send_byte(8'h03);
        t = cyc;
        repeat (6) idle_cycle();
        expect_read(t, 4'h3, exp_mem[3], t + 3);
        clear_logs();

        // ---- randomized frames against the frame-level model ----
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 3);
            a    = 4'($urandom_range(0, 15));
            case (kind)
                0: begin
                    d = 8'($urandom);
                    send_byte(8'hAA); gap(); send_byte({4'h0, a}); gap(); send_byte(d);
                    t = cyc;
                    repeat (4) idle_cycle();
                    expect_write(t, a, d);
                    exp_mem[a] = d;
                end
                1: begin
                    send_byte(8'hBB); gap(); send_byte({4'h0, a});
                    t = cyc;
                    repeat (6) idle_cycle();
                    expect_read(t, a, exp_mem[a], t + 3);
                end
                2: begin
                    op = 8'($urandom);
                    if (op == 8'hAA || op == 8'hBB) op = 8'h00;
                    send_byte(op);
                    t = cyc;
                    repeat (3) idle_cycle();
                    expect_err(t);
                end
                default: begin
                    op = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hBB;
                    a8 = {4'($urandom_range(1, 15)), 4'($urandom)};
                    send_byte(op); gap(); send_byte(a8);
                    t = cyc;
                    repeat (3) idle_cycle();
                    expect_err(t);
                end
            endcase
            clear_logs();
        end

        check("wr_rd_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_cmd_ctrl
`default_nettype wire
